// File: rtl/multdiv_seq.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the EX stage.
// Restoring shift-subtract division, one quotient bit per cycle, with a sign-fix cycle.
module multdiv_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [1:0]            op_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   // Handshake: start_i is a request held by the pipeline until the one-cycle valid_o
   // pulse; it is consumed only in IDLE, and flush_i always wins over start_i.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t state, state_nx;

   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  rem_sel_q;
   logic                  quo_neg_q;
   logic                  rem_neg_q;
   logic [DATA_WIDTH-1:0] dvd_q;
   logic [DATA_WIDTH-1:0] dsr_q;
   logic [DATA_WIDTH-1:0] quo_q;
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] result_q;

   logic                  accept;
   logic                  is_signed;
   logic                  is_rem;
   logic                  dvd_neg;
   logic                  dsr_neg;
   logic                  div_zero;
   logic                  overflow;
   logic                  special;
   logic [DATA_WIDTH-1:0] dvd_abs;
   logic [DATA_WIDTH-1:0] dsr_abs;
   logic [DATA_WIDTH-1:0] special_res;

   logic [DATA_WIDTH:0]   rem_shift;
   logic [DATA_WIDTH:0]   diff;
   logic                  qbit;
   logic [DATA_WIDTH-1:0] rem_step;
   logic [DATA_WIDTH-1:0] fix_res;

   // Operand decode, only meaningful in the accept cycle.
   always_comb begin
      accept      = (state == IDLE) && start_i && !flush_i;
      is_signed   = !op_i[0];
      is_rem      = op_i[1];
      dvd_neg     = is_signed && dividend_i[DATA_WIDTH-1];
      dsr_neg     = is_signed && divisor_i[DATA_WIDTH-1];
      dvd_abs     = dvd_neg ? -dividend_i : dividend_i;
      dsr_abs     = dsr_neg ? -divisor_i  : divisor_i;
      div_zero    = (divisor_i == '0);
      overflow    = is_signed && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
      special     = div_zero || overflow;
      special_res = '0;
      if (div_zero) begin
         special_res = is_rem ? dividend_i : ALL_ONES;
      end else if (overflow) begin
         special_res = is_rem ? '0 : MIN_NEG;
      end
   end

   // One restoring step; the borrow out of the widened subtract decides the quotient bit.
   always_comb begin
      rem_shift = {rem_q, dvd_q[DATA_WIDTH-1]};
      diff      = rem_shift - {1'b0, dsr_q};
      qbit      = !diff[DATA_WIDTH];
      rem_step  = qbit ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
   end

   always_comb begin
      fix_res = '0;
      if (rem_sel_q) begin
         fix_res = rem_neg_q ? -rem_q : rem_q;
      end else begin
         fix_res = quo_neg_q ? -quo_q : quo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      stall_o  = 1'b0;
      busy_o   = 1'b1;
      valid_o  = 1'b0;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (accept) begin
               stall_o  = 1'b1;
               state_nx = special ? DONE : CALC;
            end
         end
         CALC: begin
            stall_o = 1'b1;
            if (cnt_q == '0) begin
               state_nx = FIX;
            end
         end
         FIX: begin
            stall_o  = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            valid_o  = !flush_i;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (flush_i) begin
         state_nx = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         rem_sel_q <= 1'b0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         result_q  <= '0;
      end else if (flush_i) begin
         cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  rem_sel_q <= is_rem;
                  quo_neg_q <= dvd_neg ^ dsr_neg;
                  rem_neg_q <= dvd_neg;
                  dvd_q     <= dvd_abs;
                  dsr_q     <= dsr_abs;
                  quo_q     <= '0;
                  rem_q     <= '0;
                  if (special) begin
                     result_q <= special_res;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= CNT_LAST;
                  end
               end
            end
            CALC: begin
               dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
               rem_q <= rem_step;
               quo_q <= {quo_q[DATA_WIDTH-2:0], qbit};
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIX: begin
               result_q <= fix_res;
            end
            default: begin
            end
         endcase
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed vector table, hand-written corner
// sequences (flush, reset, back-to-back) and randomized ops against an arithmetic model.
module tb_multdiv_seq;

   localparam int W        = 32;
   localparam int LAT_NORM = W + 2;
   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [1:0]   op_i;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         flush_i;
   logic         stall_o;
   logic         busy_o;
   logic         valid_o;
   logic [W-1:0] result_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   multdiv_seq #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic, RISC-V divide-by-zero rules.
   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint sa, sb, q, r;
      if (b == '0) return op[1] ? a : '1;
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return op[1] ? r[W-1:0] : q[W-1:0];
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      if (b == '0) return 1;
      if (!op[0] && a == MIN_NEG && b == '1) return 1;
      return LAT_NORM;
   endfunction

   // Driver: raises start_i in cycle 0, scrambles operands after accept, waits for valid_o.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output logic stall_ok,
                         output int v_cyc);
      res   = '0;
      lat   = -1;
      v_cyc = -1;
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      #1;
      stall_ok = stall_o;
      for (int c = 1; c <= 100 && lat < 0; c++) begin
         @(negedge clk);
         if (valid_o) begin
            lat   = c;
            res   = result_o;
            v_cyc = cyc;
            if (stall_o || !busy_o) stall_ok = 1'b0;
         end else begin
            if (!stall_o || !busy_o) stall_ok = 1'b0;
            op_i       = 2'($urandom);
            dividend_i = $urandom;
            divisor_i  = $urandom;
         end
      end
      start_i = 1'b0;
   endtask

   task automatic watch_no_valid(input int n, output int seen);
      seen = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (valid_o) seen++;
      end
   endtask

   initial begin
      logic [W-1:0] res;
      logic [W-1:0] res2;
      int           lat;
      int           vc1;
      int           vc2;
      int           seen;
      logic         sok;
      logic [1:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           rlat;

      vecs.push_back('{OP_DIV,  32'd100,       32'd7,         32'd14,        LAT_NORM});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORM});
      vecs.push_back('{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORM});
      vecs.push_back('{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{OP_REMU, 32'd5,         32'd0,         32'd5,         1});
      vecs.push_back('{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
      vecs.push_back('{OP_DIVU, 32'd0,         32'd5,         32'd0,         LAT_NORM});
      vecs.push_back('{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_NORM});
      vecs.push_back('{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        LAT_NORM});
      vecs.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,         LAT_NORM});
      vecs.push_back('{OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
      vecs.push_back('{OP_DIV,  32'h8000_0000, 32'd1,         32'h8000_0000, LAT_NORM});
      vecs.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_NORM});
      vecs.push_back('{OP_REMU, 32'd3,         32'd7,         32'd3,         LAT_NORM});

      // Reset
      rst_n      = 1'b0;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      op_i       = '0;
      dividend_i = '0;
      divisor_i  = '0;
      #2;
      check("reset_stall",  W'(stall_o),  '0);
      check("reset_busy",   W'(busy_o),   '0);
      check("reset_valid",  W'(valid_o),  '0);
      check("reset_result", result_o,     '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, sok, vc1);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].lat));
         check($sformatf("vec%0d_stall", i), W'(sok), W'(1));
      end

      // Flush in cycle 10 of a DIVU
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = OP_DIVU;
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      check("flush_busy_next", W'(busy_o), '0);
      check("flush_beats_start_stall", W'(stall_o), '0);
      flush_i = 1'b0;
      start_i = 1'b0;
      watch_no_valid(40, seen);
      check("flush_no_valid", W'(seen), '0);
      run_op(OP_DIVU, 32'd9, 32'd3, res, lat, sok, vc1);
      check("after_flush_result", res, 32'd3);
      check("after_flush_latency", W'(lat), W'(LAT_NORM));

      // Flush together with start in IDLE
      @(negedge clk);
      start_i    = 1'b1;
      flush_i    = 1'b1;
      op_i       = OP_DIV;
      dividend_i = 32'd50;
      divisor_i  = 32'd5;
      #1;
      check("idle_flush_stall", W'(stall_o), '0);
      @(negedge clk);
      check("idle_flush_busy", W'(busy_o), '0);
      start_i = 1'b0;
      flush_i = 1'b0;

      // Flush in DONE suppresses valid_o
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = OP_DIVU;
      dividend_i = 32'd5;
      divisor_i  = 32'd0;
      @(negedge clk);
      check("done_busy", W'(busy_o), W'(1));
      flush_i = 1'b1;
      start_i = 1'b0;
      #1;
      check("done_flush_valid", W'(valid_o), '0);
      @(negedge clk);
      flush_i = 1'b0;
      check("done_flush_idle", W'(busy_o), '0);

      // Reset in cycle 20 of an op
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = OP_DIVU;
      dividend_i = 32'hFFFF_FFFF;
      divisor_i  = 32'd7;
      repeat (20) @(negedge clk);
      rst_n   = 1'b0;
      start_i = 1'b0;
      #1;
      check("midreset_busy",   W'(busy_o),  '0);
      check("midreset_stall",  W'(stall_o), '0);
      check("midreset_valid",  W'(valid_o), '0);
      check("midreset_result", result_o,    '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid(40, seen);
      check("midreset_no_valid", W'(seen), '0);

      // Back-to-back
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, res, lat, sok, vc1);
      run_op(OP_REMU, 32'd10, 32'd3, res2, lat, sok, vc2);
      check("b2b_first",  res,  32'hFFFF_FFFF);
      check("b2b_second", res2, 32'd1);
      check("b2b_gap", W'(vc2 - vc1), W'(LAT_NORM + 1));

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: begin ra = MIN_NEG; rb = '1; end
            2: rb = W'($urandom_range(1, 15));
            3: ra = W'($urandom_range(0, 100));
            default: ;
         endcase
         exp_q.push_back(ref_result(rop, ra, rb));
         rlat = ref_latency(rop, ra, rb);
         run_op(rop, ra, rb, res, lat, sok, vc1);
         check($sformatf("rand%0d_result", i), res, exp_q.pop_front());
         check($sformatf("rand%0d_latency", i), W'(lat), W'(rlat));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
